// File: rtl/rr_txn_arbiter_pkg.sv
// Shared constants for the round-robin transaction arbiter.
// Holds the legal parameter ranges checked at elaboration.
package rr_txn_arbiter_pkg;

    localparam int MIN_NUM_REQ   = 2;
    localparam int MAX_NUM_REQ   = 14;
    localparam int MIN_MAX_BEATS = 2;

endpackage

// File: rtl/rr_txn_arbiter_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of req (index 0 wins).
// found is low when req is all zeros, in which case idx is 0.
module priority_encoder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]         req,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     found
);

    localparam int IDX_W = $clog2(WIDTH);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign found = |req;

endmodule

// File: rtl/rr_txn_arbiter.sv
// Round-robin arbiter that locks one requester onto the downstream port for a
// whole transaction, releasing on last, on a dropped request or at the beat cap.
module rr_txn_arbiter
    import rr_txn_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BEATS = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         request,
    input  logic [NUM_REQ-1:0]         last,
    input  logic                       ready,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [NUM_REQ-1:0]         grant_onehot,
    output logic                       txn_done,
    output logic                       abort,
    output logic                       overrun
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    localparam logic [ID_W-1:0]  LAST_ID     = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]    NUM_REQ_EXT = (ID_W + 1)'(NUM_REQ);
    localparam logic [CNT_W-1:0] CAP         = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] CAP_M1      = CNT_W'(MAX_BEATS - 1);

    if (NUM_REQ < MIN_NUM_REQ || NUM_REQ > MAX_NUM_REQ) begin : g_bad_num_req
        $error("rr_txn_arbiter: NUM_REQ=%0d outside %0d..%0d",
               NUM_REQ, MIN_NUM_REQ, MAX_NUM_REQ);
    end

    if (MAX_BEATS < MIN_MAX_BEATS) begin : g_bad_max_beats
        $error("rr_txn_arbiter: MAX_BEATS=%0d below %0d", MAX_BEATS, MIN_MAX_BEATS);
    end

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  ptr_next;
    logic [ID_W-1:0]  ptr_after;
    logic [ID_W-1:0]  grant_id_next;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] beat_cnt_next;
    logic             done_next;
    logic             abort_next;
    logic             overrun_next;

    logic             locked;
    logic             owner_req;
    logic             owner_last;
    logic             beat_acc;
    logic             rel_abort;
    logic             rel_done;
    logic             rel_overrun;
    logic             release_now;

    logic [ID_W-1:0]      arb_ptr;
    logic [2*NUM_REQ-1:0] doubled;
    logic [NUM_REQ-1:0]   rotated;
    logic [ID_W-1:0]      enc_idx;
    logic                 any_req;
    logic [ID_W:0]        winner_sum;
    logic [ID_W-1:0]      winner;

    // Release detection; abort outranks the beat-based releases, and an
    // accepted beat already implies the owner's request is high.
    always_comb begin
        locked      = (state == LOCKED);
        owner_req   = request[grant_id];
        owner_last  = last[grant_id];
        beat_acc    = locked & owner_req & ready;
        rel_abort   = locked & ~owner_req;
        rel_done    = beat_acc & owner_last;
        rel_overrun = beat_acc & ~owner_last & (beat_cnt == CAP_M1);
        release_now = rel_abort | rel_done | rel_overrun;
        ptr_after   = (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
    end

    // On a release the new pointer is used immediately so the next owner is
    // chosen in the same cycle and the departing owner ranks last.
    always_comb begin
        arb_ptr = release_now ? ptr_after : ptr;
        doubled = {request, request} >> arb_ptr;
        rotated = doubled[NUM_REQ-1:0];
    end

    priority_encoder #(
        .WIDTH (NUM_REQ)
    ) u_prio_enc (
        .req   (rotated),
        .idx   (enc_idx),
        .found (any_req)
    );

    always_comb begin
        winner_sum = {1'b0, enc_idx} + {1'b0, arb_ptr};
        if (winner_sum >= NUM_REQ_EXT) begin
            winner = ID_W'(winner_sum - NUM_REQ_EXT);
        end else begin
            winner = winner_sum[ID_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
            txn_done <= 1'b0;
            abort    <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            grant_id <= grant_id_next;
            beat_cnt <= beat_cnt_next;
            txn_done <= done_next;
            abort    <= abort_next;
            overrun  <= overrun_next;
        end
    end

    always_comb begin
        state_next    = state;
        ptr_next      = ptr;
        grant_id_next = grant_id;
        beat_cnt_next = beat_cnt;
        done_next     = 1'b0;
        abort_next    = 1'b0;
        overrun_next  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next    = LOCKED;
                    grant_id_next = winner;
                    beat_cnt_next = '0;
                end
            end
            LOCKED: begin
                if (release_now) begin
                    ptr_next      = ptr_after;
                    done_next     = rel_done;
                    abort_next    = rel_abort;
                    overrun_next  = rel_overrun;
                    beat_cnt_next = '0;
                    if (any_req) begin
                        grant_id_next = winner;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (beat_acc && beat_cnt != CAP) begin
                    beat_cnt_next = beat_cnt + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        grant_valid  = locked & owner_req;
        grant_onehot = locked ? (NUM_REQ'(1) << grant_id) : '0;
    end

endmodule

// File: tb/tb_rr_txn_arbiter.sv
// Directed bench for rr_txn_arbiter (NUM_REQ=4, MAX_BEATS=4): a table of
// per-cycle vectors followed by an asynchronous-reset-while-locked sequence.
module tb_rr_txn_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int MAX_BEATS = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] request = '0;
    logic [3:0] last = '0;
    logic       ready = 1'b0;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic [3:0] grant_onehot;
    logic       txn_done;
    logic       abort;
    logic       overrun;

    int applied = 0;
    int miscompares = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] lst;
        logic       rdy;
        logic       gv;
        logic [1:0] gid;
        logic       chk_id;
        logic [3:0] oh;
        logic       done;
        logic       abrt;
        logic       ovr;
    } vec_t;

    vec_t vecs[$];

    rr_txn_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .request      (request),
        .last         (last),
        .ready        (ready),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .grant_onehot (grant_onehot),
        .txn_done     (txn_done),
        .abort        (abort),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic [3:0] lst,
                                input logic rdy, input logic gv, input logic [1:0] gid,
                                input logic chk_id, input logic [3:0] oh,
                                input logic d, input logic a, input logic o);
        vec_t v;
        v.rst = rst;  v.req = req; v.lst = lst; v.rdy = rdy;
        v.gv = gv;    v.gid = gid; v.chk_id = chk_id; v.oh = oh;
        v.done = d;   v.abrt = a;  v.ovr = o;
        return v;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic apply_stimulus(input logic rst, input logic [3:0] req,
                                  input logic [3:0] lst, input logic rdy);
        @(negedge clk);
        rst_n   = ~rst;
        request = req;
        last    = lst;
        ready   = rdy;
        #1;
    endtask

    task automatic check_output(input int id, input logic e_gv, input logic [1:0] e_gid,
                                input logic chk_id, input logic [3:0] e_oh,
                                input logic e_d, input logic e_a, input logic e_o);
        applied++;
        if (grant_valid !== e_gv) begin
            miscompares++;
            $display("[TB] FAIL vec %0d grant_valid: got %b, required %b", id, grant_valid, e_gv);
        end
        if (chk_id && grant_id !== e_gid) begin
            miscompares++;
            $display("[TB] FAIL vec %0d grant_id: got %0d, required %0d", id, grant_id, e_gid);
        end
        if (grant_onehot !== e_oh) begin
            miscompares++;
            $display("[TB] FAIL vec %0d grant_onehot: got %b, required %b", id, grant_onehot, e_oh);
        end
        if (txn_done !== e_d) begin
            miscompares++;
            $display("[TB] FAIL vec %0d txn_done: got %b, required %b", id, txn_done, e_d);
        end
        if (abort !== e_a) begin
            miscompares++;
            $display("[TB] FAIL vec %0d abort: got %b, required %b", id, abort, e_a);
        end
        if (overrun !== e_o) begin
            miscompares++;
            $display("[TB] FAIL vec %0d overrun: got %b, required %b", id, overrun, e_o);
        end
    endtask

    initial begin
        //                rst   req      last     rdy   gv    gid    chk   onehot   done  abrt  ovr
        // reset, idle, then single request 0100 with three beats
        vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0));
        // sole requester is re-granted, then drops its request
        vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0));
        // reset again, then everyone requests single-beat transactions
        vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1000, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0));
        // owner 1 under back-pressure for five cycles, then four beats ending on last
        vecs.push_back(mk(1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 4'b0010, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0));
        // re-granted owner 1 ends quickly; requester 0 wins next
        vecs.push_back(mk(1'b0, 4'b0011, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0));
        // owner 0 never asserts last: beat cap releases it, requester 1 follows
        vecs.push_back(mk(1'b0, 4'b0011, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1'b0, 4'b0011, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 4'b0011, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b1));
        // hand over to 3, which aborts after one beat; 0 is granted next
        vecs.push_back(mk(1'b0, 4'b1011, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 4'b1001, 4'b0000, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1000, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 2'd3, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0));

        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].rst, vecs[i].req, vecs[i].lst, vecs[i].rdy);
            check_output(i, vecs[i].gv, vecs[i].gid, vecs[i].chk_id, vecs[i].oh,
                         vecs[i].done, vecs[i].abrt, vecs[i].ovr);
        end

        // Reset asserted mid-transaction; pointer is 1 going in, 0 after reset.
        apply_stimulus(1'b0, 4'b0100, 4'b0000, 1'b1);
        check_output(100, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'b0100, 4'b0000, 1'b1);
        check_output(101, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_output(102, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
        check_output(103, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'b0010, 4'b0000, 1'b0);
        check_output(104, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'b0010, 4'b0000, 1'b0);
        check_output(105, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
